// File: rtl/supercar_pkg.sv
// Shared definitions for the Supercar scanner: pattern encodings and small
// width / one-hot helpers used by the scanner and its prescaler.
package supercar_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'd0,
        MODE_TRAIL  = 2'd1,
        MODE_WRAP   = 2'd2,
        MODE_MIRROR = 2'd3
    } mode_t;

    localparam int MAX_LEDS = 64;

    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Indices outside the vector shift the single bit out and yield all zeros.
    function automatic logic [MAX_LEDS-1:0] onehot(input int unsigned idx);
        logic [MAX_LEDS-1:0] v;
        v = {{(MAX_LEDS-1){1'b0}}, 1'b1};
        return v << idx;
    endfunction

endpackage

// File: rtl/supercar_prescaler.sv
// Scan-rate prescaler: counts a speed-dependent period and emits one tick per
// period; pause freezes the count and a clear input restarts it.
module supercar_prescaler #(
    parameter int DIV_BASE     = 5_000_000,
    parameter int SPEED_LEVELS = 4,
    parameter int LVL_W        = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [LVL_W-1:0] i_speed_lvl,
    input  logic             i_pause,
    input  logic             i_clear,
    output logic             o_tick
);
    import supercar_pkg::*;

    localparam int CNT_W = width_of(DIV_BASE * SPEED_LEVELS + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_period;
    logic             w_at_end;

    assign w_period = CNT_W'(DIV_BASE) * (CNT_W'(SPEED_LEVELS) - CNT_W'(i_speed_lvl));
    assign w_at_end = (r_cnt >= (w_period - CNT_W'(1)));
    assign o_tick   = w_at_end && !i_pause;

    // A speed change restarts the period even while paused.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (!i_pause) begin
            if (w_at_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/supercar_scanner.sv
// Supercar LED bar scanner: four scan patterns, adjustable speed, fading
// trail history and a lap counter for the HEX readout.
module supercar_scanner #(
    parameter int N_LEDS       = 10,
    parameter int DIV_BASE     = 5_000_000,
    parameter int SPEED_LEVELS = 4,
    parameter int TRAIL        = 3,
    parameter int LAP_W        = 8
) (
    input  logic                            CLOCK_50,
    input  logic                            rst,
    input  logic [1:0]                      mode,
    input  logic                            speed_up,
    input  logic                            speed_dn,
    input  logic                            pause,
    output logic [N_LEDS-1:0]               leds,
    output logic [$clog2(N_LEDS)-1:0]       pos,
    output logic                            dir,
    output logic [$clog2(SPEED_LEVELS)-1:0] speed_lvl,
    output logic [LAP_W-1:0]                lap_cnt,
    output logic                            step
);
    import supercar_pkg::*;

    localparam int POS_W = $clog2(N_LEDS);
    localparam int LVL_W = $clog2(SPEED_LEVELS);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LEDS - 1);
    localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(SPEED_LEVELS - 1);

    mode_t             r_mode;
    logic [POS_W-1:0]  r_pos;
    logic              r_dir;
    logic [LAP_W-1:0]  r_lap;
    logic              r_step;
    logic [LVL_W-1:0]  r_speed;
    logic [N_LEDS-1:0] r_hist [TRAIL];

    mode_t             w_req_mode;
    logic              w_tick;
    logic              w_speed_inc;
    logic              w_speed_dec;
    logic              w_speed_chg;
    logic [POS_W-1:0]  w_next_pos;
    logic              w_next_dir;
    logic              w_lap;
    logic [N_LEDS-1:0] w_head;
    logic [N_LEDS-1:0] w_mirror;
    logic [N_LEDS-1:0] w_trail;

    assign w_req_mode  = mode_t'(mode);
    assign w_speed_inc = speed_up && !speed_dn && (r_speed != LVL_MAX);
    assign w_speed_dec = speed_dn && !speed_up && (r_speed != '0);
    assign w_speed_chg = w_speed_inc || w_speed_dec;

    supercar_prescaler #(
        .DIV_BASE     (DIV_BASE),
        .SPEED_LEVELS (SPEED_LEVELS),
        .LVL_W        (LVL_W)
    ) u_prescaler (
        .i_clk       (CLOCK_50),
        .i_rst       (rst),
        .i_speed_lvl (r_speed),
        .i_pause     (pause),
        .i_clear     (w_speed_chg),
        .o_tick      (w_tick)
    );

    always_comb begin
        w_next_pos = r_pos;
        w_next_dir = r_dir;
        w_lap      = 1'b0;
        if (r_mode == MODE_WRAP) begin
            w_next_dir = 1'b0;
            if (r_pos == POS_LAST) begin
                w_next_pos = '0;
                w_lap      = 1'b1;
            end else begin
                w_next_pos = r_pos + POS_W'(1);
            end
        end else if (!r_dir) begin
            w_next_pos = r_pos + POS_W'(1);
            if (r_pos == POS_LAST - POS_W'(1)) begin
                w_next_dir = 1'b1;
            end
        end else begin
            w_next_pos = r_pos - POS_W'(1);
            if (r_pos == POS_W'(1)) begin
                w_next_dir = 1'b0;
                w_lap      = 1'b1;
            end
        end
    end

    // A mode change is only taken on a tick and restarts the scan from LED 0.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_mode  <= MODE_BOUNCE;
            r_pos   <= '0;
            r_dir   <= 1'b0;
            r_lap   <= '0;
            r_step  <= 1'b0;
            r_speed <= '0;
            for (int i = 0; i < TRAIL; i++) begin
                r_hist[i] <= '0;
            end
        end else begin
            r_step <= w_tick;
            if (w_speed_inc) begin
                r_speed <= r_speed + LVL_W'(1);
            end else if (w_speed_dec) begin
                r_speed <= r_speed - LVL_W'(1);
            end
            if (w_tick) begin
                if (w_req_mode != r_mode) begin
                    r_mode <= w_req_mode;
                    r_pos  <= '0;
                    r_dir  <= 1'b0;
                    for (int i = 0; i < TRAIL; i++) begin
                        r_hist[i] <= '0;
                    end
                end else begin
                    for (int i = TRAIL - 1; i > 0; i--) begin
                        r_hist[i] <= r_hist[i-1];
                    end
                    r_hist[0] <= w_head;
                    r_pos     <= w_next_pos;
                    r_dir     <= w_next_dir;
                    if (w_lap) begin
                        r_lap <= r_lap + LAP_W'(1);
                    end
                end
            end
        end
    end

    assign w_head   = N_LEDS'(onehot(32'(r_pos)));
    assign w_mirror = N_LEDS'(onehot(32'(POS_LAST - r_pos)));

    always_comb begin
        w_trail = '0;
        for (int i = 0; i < TRAIL; i++) begin
            w_trail = w_trail | r_hist[i];
        end
    end

    always_comb begin
        case (r_mode)
            MODE_TRAIL:  leds = w_head | w_trail;
            MODE_MIRROR: leds = w_head | w_mirror;
            default:     leds = w_head;
        endcase
    end

    assign pos       = r_pos;
    assign dir       = r_dir;
    assign speed_lvl = r_speed;
    assign lap_cnt   = r_lap;
    assign step      = r_step;

endmodule

// File: tb/tb_supercar_scanner.sv
// Self-checking bench for supercar_scanner with a small configuration
// (10 LEDs, DIV_BASE=2, 4 speed levels, trail of 3) so P=8 at speed 0.
module tb_supercar_scanner;

    logic       CLOCK_50 = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       speed_up;
    logic       speed_dn;
    logic       pause;
    logic [9:0] leds;
    logic [3:0] pos;
    logic       dir;
    logic [1:0] speed_lvl;
    logic [7:0] lap_cnt;
    logic       step;

    typedef struct {
        logic [1:0] mode;
        logic [3:0] pos;
        logic       dir;
        logic [7:0] lap;
        logic [9:0] leds;
    } vec_t;

    typedef struct {
        logic [3:0] pos;
        logic       dir;
        logic [7:0] lap;
        logic [9:0] leds;
    } exp_t;

    localparam int NVEC = 40;

    vec_t vecs [NVEC];
    exp_t sbq [$];
    int   testsRun    = 0;
    int   testsFailed = 0;

    supercar_scanner #(
        .N_LEDS       (10),
        .DIV_BASE     (2),
        .SPEED_LEVELS (4),
        .TRAIL        (3),
        .LAP_W        (8)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .rst       (rst),
        .mode      (mode),
        .speed_up  (speed_up),
        .speed_dn  (speed_dn),
        .pause     (pause),
        .leds      (leds),
        .pos       (pos),
        .dir       (dir),
        .speed_lvl (speed_lvl),
        .lap_cnt   (lap_cnt),
        .step      (step)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic waitStep(input int limit, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (!ok && cycles < limit) begin
            @(negedge CLOCK_50);
            cycles++;
            if (step === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL step_timeout: no step within %0d clocks, expected one", limit);
        end
    endtask

    task automatic setRow(input int i, input logic [1:0] m, input logic [3:0] p,
                          input logic d, input logic [7:0] l, input logic [9:0] ld);
        vecs[i] = '{m, p, d, l, ld};
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        mode = v.mode;
        e    = '{v.pos, v.dir, v.lap, v.leds};
        sbq.push_back(e);
    endtask

    task automatic checkOutput(input int idx, input int interval);
        int   cyc;
        bit   ok;
        exp_t e;
        waitStep(40, cyc, ok);
        e = sbq.pop_front();
        if (ok) begin
            checkVal($sformatf("row%0d_interval", idx), 32'(cyc), 32'(interval));
            checkVal($sformatf("row%0d_pos", idx), 32'(pos), 32'(e.pos));
            checkVal($sformatf("row%0d_dir", idx), 32'(dir), 32'(e.dir));
            checkVal($sformatf("row%0d_lap", idx), 32'(lap_cnt), 32'(e.lap));
            checkVal($sformatf("row%0d_leds", idx), 32'(leds), 32'(e.leds));
        end
    endtask

    task automatic pulse(input logic up, input logic dn);
        speed_up = up;
        speed_dn = dn;
        @(negedge CLOCK_50);
        speed_up = 1'b0;
        speed_dn = 1'b0;
        @(negedge CLOCK_50);
    endtask

    initial begin
        int  cyc;
        bit  ok;
        bit  sawStep;
        bit  frozenOk;
        bit  dirOk;
        bit  intervalOk;

        // Expected sequence: bounce 20 ticks, trail restart, wrap lap, mirror, bounce.
        setRow( 0, 2'd0, 4'd1, 1'b0, 8'd0, 10'h002);
        setRow( 1, 2'd0, 4'd2, 1'b0, 8'd0, 10'h004);
        setRow( 2, 2'd0, 4'd3, 1'b0, 8'd0, 10'h008);
        setRow( 3, 2'd0, 4'd4, 1'b0, 8'd0, 10'h010);
        setRow( 4, 2'd0, 4'd5, 1'b0, 8'd0, 10'h020);
        setRow( 5, 2'd0, 4'd6, 1'b0, 8'd0, 10'h040);
        setRow( 6, 2'd0, 4'd7, 1'b0, 8'd0, 10'h080);
        setRow( 7, 2'd0, 4'd8, 1'b0, 8'd0, 10'h100);
        setRow( 8, 2'd0, 4'd9, 1'b1, 8'd0, 10'h200);
        setRow( 9, 2'd0, 4'd8, 1'b1, 8'd0, 10'h100);
        setRow(10, 2'd0, 4'd7, 1'b1, 8'd0, 10'h080);
        setRow(11, 2'd0, 4'd6, 1'b1, 8'd0, 10'h040);
        setRow(12, 2'd0, 4'd5, 1'b1, 8'd0, 10'h020);
        setRow(13, 2'd0, 4'd4, 1'b1, 8'd0, 10'h010);
        setRow(14, 2'd0, 4'd3, 1'b1, 8'd0, 10'h008);
        setRow(15, 2'd0, 4'd2, 1'b1, 8'd0, 10'h004);
        setRow(16, 2'd0, 4'd1, 1'b1, 8'd0, 10'h002);
        setRow(17, 2'd0, 4'd0, 1'b0, 8'd1, 10'h001);
        setRow(18, 2'd0, 4'd1, 1'b0, 8'd1, 10'h002);
        setRow(19, 2'd0, 4'd2, 1'b0, 8'd1, 10'h004);
        setRow(20, 2'd1, 4'd0, 1'b0, 8'd1, 10'h001);
        setRow(21, 2'd1, 4'd1, 1'b0, 8'd1, 10'h003);
        setRow(22, 2'd1, 4'd2, 1'b0, 8'd1, 10'h007);
        setRow(23, 2'd1, 4'd3, 1'b0, 8'd1, 10'h00F);
        setRow(24, 2'd1, 4'd4, 1'b0, 8'd1, 10'h01E);
        setRow(25, 2'd2, 4'd0, 1'b0, 8'd1, 10'h001);
        setRow(26, 2'd2, 4'd1, 1'b0, 8'd1, 10'h002);
        setRow(27, 2'd2, 4'd2, 1'b0, 8'd1, 10'h004);
        setRow(28, 2'd2, 4'd3, 1'b0, 8'd1, 10'h008);
        setRow(29, 2'd2, 4'd4, 1'b0, 8'd1, 10'h010);
        setRow(30, 2'd2, 4'd5, 1'b0, 8'd1, 10'h020);
        setRow(31, 2'd2, 4'd6, 1'b0, 8'd1, 10'h040);
        setRow(32, 2'd2, 4'd7, 1'b0, 8'd1, 10'h080);
        setRow(33, 2'd2, 4'd8, 1'b0, 8'd1, 10'h100);
        setRow(34, 2'd2, 4'd9, 1'b0, 8'd1, 10'h200);
        setRow(35, 2'd2, 4'd0, 1'b0, 8'd2, 10'h001);
        setRow(36, 2'd3, 4'd0, 1'b0, 8'd2, 10'h201);
        setRow(37, 2'd3, 4'd1, 1'b0, 8'd2, 10'h102);
        setRow(38, 2'd3, 4'd2, 1'b0, 8'd2, 10'h084);
        setRow(39, 2'd0, 4'd0, 1'b0, 8'd2, 10'h001);

        rst      = 1'b1;
        mode     = 2'd0;
        speed_up = 1'b0;
        speed_dn = 1'b0;
        pause    = 1'b0;
        repeat (2) @(negedge CLOCK_50);

        checkVal("reset_pos", 32'(pos), 32'(0));
        checkVal("reset_dir", 32'(dir), 32'(0));
        checkVal("reset_speed", 32'(speed_lvl), 32'(0));
        checkVal("reset_lap", 32'(lap_cnt), 32'(0));
        checkVal("reset_step", 32'(step), 32'(0));
        checkVal("reset_leds", 32'(leds), 32'(10'h001));

        rst = 1'b0;
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i, 8);
        end

        // Pause mid-period with three clocks already counted, then resume.
        repeat (3) @(negedge CLOCK_50);
        pause    = 1'b1;
        sawStep  = 1'b0;
        frozenOk = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLOCK_50);
            if (step !== 1'b0) sawStep = 1'b1;
            if (pos !== 4'd0 || leds !== 10'h001 || dir !== 1'b0 || lap_cnt !== 8'd2) frozenOk = 1'b0;
        end
        checkVal("pause_no_step", 32'(sawStep), 32'(0));
        checkVal("pause_frozen", 32'(frozenOk), 32'(1));
        pause = 1'b0;
        waitStep(40, cyc, ok);
        if (ok) begin
            checkVal("pause_resume_interval", 32'(cyc), 32'(5));
            checkVal("pause_resume_pos", 32'(pos), 32'(1));
        end

        // Both speed pulses together: no change and the count keeps running.
        repeat (3) @(negedge CLOCK_50);
        speed_up = 1'b1;
        speed_dn = 1'b1;
        @(negedge CLOCK_50);
        speed_up = 1'b0;
        speed_dn = 1'b0;
        waitStep(40, cyc, ok);
        if (ok) checkVal("both_pulses_interval", 32'(cyc), 32'(4));
        checkVal("both_pulses_speed", 32'(speed_lvl), 32'(0));

        repeat (3) @(negedge CLOCK_50);
        speed_dn = 1'b1;
        @(negedge CLOCK_50);
        speed_dn = 1'b0;
        waitStep(40, cyc, ok);
        if (ok) checkVal("dn_at_zero_interval", 32'(cyc), 32'(4));
        checkVal("dn_at_zero_speed", 32'(speed_lvl), 32'(0));

        repeat (3) @(negedge CLOCK_50);
        speed_up = 1'b1;
        @(negedge CLOCK_50);
        speed_up = 1'b0;
        waitStep(40, cyc, ok);
        if (ok) checkVal("speedup_clear_interval", 32'(cyc), 32'(6));
        checkVal("speedup_level1", 32'(speed_lvl), 32'(1));

        repeat (4) pulse(1'b1, 1'b0);
        checkVal("speed_saturate", 32'(speed_lvl), 32'(3));
        waitStep(40, cyc, ok);
        waitStep(40, cyc, ok);
        if (ok) checkVal("speed3_interval", 32'(cyc), 32'(2));

        pulse(1'b0, 1'b1);
        checkVal("speed_dn_level", 32'(speed_lvl), 32'(2));
        waitStep(40, cyc, ok);
        waitStep(40, cyc, ok);
        if (ok) checkVal("speed2_interval", 32'(cyc), 32'(4));

        pause = 1'b1;
        @(negedge CLOCK_50);
        pulse(1'b0, 1'b1);
        checkVal("paused_dn_level", 32'(speed_lvl), 32'(1));
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        checkVal("paused_up_level", 32'(speed_lvl), 32'(3));
        pause = 1'b0;

        // Asynchronous reset between clock edges must act immediately.
        repeat (5) @(negedge CLOCK_50);
        #2 rst = 1'b1;
        #1;
        checkVal("async_rst_pos", 32'(pos), 32'(0));
        checkVal("async_rst_dir", 32'(dir), 32'(0));
        checkVal("async_rst_speed", 32'(speed_lvl), 32'(0));
        checkVal("async_rst_lap", 32'(lap_cnt), 32'(0));
        checkVal("async_rst_step", 32'(step), 32'(0));
        checkVal("async_rst_leds", 32'(leds), 32'(10'h001));
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        rst = 1'b0;

        // 256 wrap laps at full speed roll the lap counter over to zero.
        repeat (3) pulse(1'b1, 1'b0);
        checkVal("lap_speed", 32'(speed_lvl), 32'(3));
        waitStep(40, cyc, ok);
        mode = 2'd2;
        waitStep(40, cyc, ok);
        checkVal("wrap_restart_pos", 32'(pos), 32'(0));
        checkVal("wrap_restart_lap", 32'(lap_cnt), 32'(0));
        dirOk      = 1'b1;
        intervalOk = 1'b1;
        for (int k = 1; k <= 2560; k++) begin
            waitStep(10, cyc, ok);
            if (!ok) break;
            if (dir !== 1'b0) dirOk = 1'b0;
            if (cyc != 2) intervalOk = 1'b0;
            if (k == 9) begin
                checkVal("wrap_top_pos", 32'(pos), 32'(9));
                checkVal("wrap_top_leds", 32'(leds), 32'(10'h200));
            end
            if (k == 10) begin
                checkVal("wrap_first_lap", 32'(lap_cnt), 32'(1));
                checkVal("wrap_first_leds", 32'(leds), 32'(10'h001));
            end
            if (k == 2550) checkVal("lap_255", 32'(lap_cnt), 32'(255));
            if (k == 2560) begin
                checkVal("lap_wrap_zero", 32'(lap_cnt), 32'(0));
                checkVal("lap_wrap_pos", 32'(pos), 32'(0));
            end
        end
        checkVal("wrap_dir_stays_0", 32'(dirOk), 32'(1));
        checkVal("wrap_interval_2", 32'(intervalOk), 32'(1));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
